// File: rtl/multi_alarm_clock.sv
// -----------------------------------------------------------------------------
// multi_alarm_clock
//   24-hour BCD time-of-day core with a programmable alarm table and a
//   ring / snooze / dismiss alarm state machine. Time and alarm entries are
//   loaded in parallel through single-cycle strobes and validated; a rejected
//   load changes nothing and pulses load_err for one cycle. An optional
//   12-hour view is decoded combinationally from the time registers.
//
// Parameters
//   TICKS_PER_SEC  clk cycles per second (>=1)
//   NUM_ALARMS     alarm table entries (1..16)
//   ALARM_SECS     ring duration in seconds (1..63)
//   SNOOZE_MIN     snooze delay in minutes (1..59)
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   time_load           strobe: load time_in_h/time_in_m, clear seconds
//   time_in_h/_m        BCD time to load
//   alarm_wr            strobe: write entry alarm_idx
//   alarm_idx           entry index (IW bits)
//   alarm_in_h/_m/_en   BCD alarm time and enable for the write
//   snooze, dismiss     single-cycle alarm requests
//   fmt_12h             select the 12-hour display view
//   hours_out           BCD display hours (24h or 12h view)
//   minutes_out         BCD minutes
//   seconds_out         BCD seconds
//   pm                  PM flag in the 12-hour view, else 0
//   alarm_sound         high while the FSM is in RING
//   ring_idx            entry that caused the current or last ring
//   load_err            one-cycle pulse after a rejected load
//   dbg_state           current alarm FSM state (debug visibility)
//
// Strobe semantics: every request input (time_load, alarm_wr, snooze,
// dismiss) is a level sampled on each rising clk edge; there is no
// back-pressure, so each cycle it is high counts as one request.
// -----------------------------------------------------------------------------
module multi_alarm_clock #(
  parameter int TICKS_PER_SEC = 1,
  parameter int NUM_ALARMS    = 4,
  parameter int ALARM_SECS    = 20,
  parameter int SNOOZE_MIN    = 5,
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          time_load,
  input  logic [5:0]    time_in_h,
  input  logic [6:0]    time_in_m,
  input  logic          alarm_wr,
  input  logic [IW-1:0] alarm_idx,
  input  logic [5:0]    alarm_in_h,
  input  logic [6:0]    alarm_in_m,
  input  logic          alarm_in_en,
  input  logic          snooze,
  input  logic          dismiss,
  input  logic          fmt_12h,
  output logic [5:0]    hours_out,
  output logic [6:0]    minutes_out,
  output logic [6:0]    seconds_out,
  output logic          pm,
  output logic          alarm_sound,
  output logic [IW-1:0] ring_idx,
  output logic          load_err,
  output logic [1:0]    dbg_state
);

  localparam int              PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0]   PRESC_ONE  = PW'(1);
  localparam logic [5:0]      RING_LAST  = 6'(ALARM_SECS - 1);
  localparam logic [11:0]     SNZ_LOAD   = 12'(SNOOZE_MIN * 60);
  localparam logic [IW:0]     NUM_AL_V   = (IW + 1)'(NUM_ALARMS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RING   = 2'd1,
    ST_SNOOZE = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [PW-1:0]   r_presc;
  logic [5:0]      r_hours;
  logic [6:0]      r_minutes;
  logic [6:0]      r_seconds;
  logic [5:0]      r_al_h [NUM_ALARMS];
  logic [6:0]      r_al_m [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] r_al_en;
  logic            r_new_sec;
  logic            r_match;
  logic [IW-1:0]   r_match_idx;
  state_t          r_state;
  logic [5:0]      r_ring_cnt;
  logic [11:0]     r_snz_cnt;
  logic [IW-1:0]   r_ring_idx;
  logic            r_alarm_sound;
  logic            r_load_err;

  // ---------------------------------------------------------------------------
  // Load validation
  // ---------------------------------------------------------------------------
  function automatic logic hours_ok(input logic [5:0] h);
    // tens 0..1 with any unit digit, or tens 2 with units 0..3
    return (h[3:0] <= 4'd9) &&
           ((h[5:4] < 2'd2) || ((h[5:4] == 2'd2) && (h[3:0] <= 4'd3)));
  endfunction

  function automatic logic minutes_ok(input logic [6:0] m);
    return (m[6:4] <= 3'd5) && (m[3:0] <= 4'd9);
  endfunction

  logic w_sec_tick;
  logic w_time_ok;
  logic w_idx_ok;
  logic w_alarm_ok;
  logic w_load_bad;

  assign w_sec_tick = (r_presc == PRESC_MAX);
  assign w_time_ok  = time_load & hours_ok(time_in_h) & minutes_ok(time_in_m);
  assign w_idx_ok   = ({1'b0, alarm_idx} < NUM_AL_V);
  assign w_alarm_ok = alarm_wr & w_idx_ok & hours_ok(alarm_in_h) & minutes_ok(alarm_in_m);
  assign w_load_bad = (time_load & ~w_time_ok) | (alarm_wr & ~w_alarm_ok);

  // ---------------------------------------------------------------------------
  // BCD increment of the time-of-day
  // ---------------------------------------------------------------------------
  logic [6:0] w_s_next;
  logic [6:0] w_m_next;
  logic [5:0] w_h_next;
  logic       w_min_carry;
  logic       w_hr_carry;

  always_comb begin
    w_s_next    = r_seconds;
    w_m_next    = r_minutes;
    w_h_next    = r_hours;
    w_min_carry = 1'b0;
    w_hr_carry  = 1'b0;

    if (r_seconds[3:0] == 4'd9) begin
      w_s_next[3:0] = 4'd0;
      if (r_seconds[6:4] == 3'd5) begin
        w_s_next[6:4] = 3'd0;
        w_min_carry   = 1'b1;
      end else begin
        w_s_next[6:4] = r_seconds[6:4] + 3'd1;
      end
    end else begin
      w_s_next[3:0] = r_seconds[3:0] + 4'd1;
    end

    if (w_min_carry) begin
      if (r_minutes[3:0] == 4'd9) begin
        w_m_next[3:0] = 4'd0;
        if (r_minutes[6:4] == 3'd5) begin
          w_m_next[6:4] = 3'd0;
          w_hr_carry    = 1'b1;
        end else begin
          w_m_next[6:4] = r_minutes[6:4] + 3'd1;
        end
      end else begin
        w_m_next[3:0] = r_minutes[3:0] + 4'd1;
      end
    end

    if (w_hr_carry) begin
      if (r_hours == 6'h23) begin
        w_h_next = 6'h00;
      end else if (r_hours[3:0] == 4'd9) begin
        w_h_next = {r_hours[5:4] + 2'd1, 4'd0};
      end else begin
        w_h_next = {r_hours[5:4], r_hours[3:0] + 4'd1};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm match: only at the start of a freshly ticked minute. Scanning from
  // the top index down lets the lowest matching index be the last one written.
  // ---------------------------------------------------------------------------
  logic          w_hit;
  logic [IW-1:0] w_hit_idx;
  logic          w_match;

  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (r_al_en[i] && (r_al_h[i] == r_hours) && (r_al_m[i] == r_minutes)) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
      end
    end
  end

  assign w_match = w_hit & r_new_sec & (r_seconds == 7'h00);

  // ---------------------------------------------------------------------------
  // Timekeeping, alarm table, match pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= '0;
      r_hours     <= '0;
      r_minutes   <= '0;
      r_seconds   <= '0;
      r_al_en     <= '0;
      r_new_sec   <= 1'b0;
      r_match     <= 1'b0;
      r_match_idx <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        r_al_h[i] <= '0;
        r_al_m[i] <= '0;
      end
    end else begin
      // A time load restarts the second, so neither the tick of this cycle
      // nor a match found against the old time may reach the FSM.
      r_new_sec   <= w_sec_tick & ~w_time_ok;
      r_match     <= w_match & ~w_time_ok;
      r_match_idx <= w_hit_idx;

      if (w_time_ok) begin
        r_hours   <= time_in_h;
        r_minutes <= time_in_m;
        r_seconds <= 7'h00;
        r_presc   <= '0;
      end else begin
        r_presc <= w_sec_tick ? '0 : (r_presc + PRESC_ONE);
        if (w_sec_tick) begin
          r_seconds <= w_s_next;
          r_minutes <= w_m_next;
          r_hours   <= w_h_next;
        end
      end

      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (w_alarm_ok && (alarm_idx == IW'(i))) begin
          r_al_h[i]  <= alarm_in_h;
          r_al_m[i]  <= alarm_in_m;
          r_al_en[i] <= alarm_in_en;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Alarm FSM. The match is registered once more before it is acted on, so
  // alarm_sound rises two edges after the edge that made seconds 00.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_ring_cnt    <= '0;
      r_snz_cnt     <= '0;
      r_ring_idx    <= '0;
      r_alarm_sound <= 1'b0;
      r_load_err    <= 1'b0;
    end else begin
      r_load_err <= w_load_bad;

      if (w_time_ok) begin
        r_state       <= ST_IDLE;
        r_alarm_sound <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (r_match) begin
              r_state       <= ST_RING;
              r_alarm_sound <= 1'b1;
              r_ring_idx    <= r_match_idx;
              r_ring_cnt    <= '0;
            end
          end
          ST_RING: begin
            if (dismiss) begin
              r_state       <= ST_IDLE;
              r_alarm_sound <= 1'b0;
            end else if (snooze) begin
              r_state       <= ST_SNOOZE;
              r_alarm_sound <= 1'b0;
              r_snz_cnt     <= SNZ_LOAD;
            end else if (w_sec_tick) begin
              if (r_ring_cnt == RING_LAST) begin
                r_state       <= ST_IDLE;
                r_alarm_sound <= 1'b0;
              end else begin
                r_ring_cnt <= r_ring_cnt + 6'd1;
              end
            end
          end
          ST_SNOOZE: begin
            if (dismiss) begin
              r_state <= ST_IDLE;
            end else if (w_sec_tick) begin
              if (r_snz_cnt == 12'd1) begin
                r_state       <= ST_RING;
                r_alarm_sound <= 1'b1;
                r_ring_cnt    <= '0;
                r_snz_cnt     <= '0;
              end else begin
                r_snz_cnt <= r_snz_cnt - 12'd1;
              end
            end
          end
          default: begin
            r_state       <= ST_IDLE;
            r_alarm_sound <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // 12-hour display view
  // ---------------------------------------------------------------------------
  logic [5:0] w_disp_h;
  logic       w_pm;

  always_comb begin
    w_disp_h = r_hours;
    w_pm     = 1'b0;
    if (fmt_12h) begin
      if (r_hours == 6'h00) begin
        w_disp_h = 6'h12;
      end else if (r_hours < 6'h12) begin
        w_disp_h = r_hours;
      end else begin
        w_pm = 1'b1;
        if (r_hours == 6'h12) begin
          w_disp_h = 6'h12;
        end else if (r_hours[5:4] == 2'd1) begin
          // 13..19 -> 01..07
          w_disp_h = {2'd0, r_hours[3:0] - 4'd2};
        end else if (r_hours[3:0] < 4'd2) begin
          // 20..21 -> 08..09
          w_disp_h = {2'd0, r_hours[3:0] + 4'd8};
        end else begin
          // 22..23 -> 10..11
          w_disp_h = {2'd1, r_hours[3:0] - 4'd2};
        end
      end
    end
  end

  assign hours_out   = w_disp_h;
  assign minutes_out = r_minutes;
  assign seconds_out = r_seconds;
  assign pm          = w_pm;
  assign alarm_sound = r_alarm_sound;
  assign ring_idx    = r_ring_idx;
  assign load_err    = r_load_err;
  assign dbg_state   = r_state;

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised time-of-day core with a programmable alarm table. It keeps BCD hours/minutes/seconds from a clock-cycle prescaler and accepts validated parallel time and alarm loads. It drives a ring/snooze/dismiss alarm state machine and offers an optional 12-hour display view. It replaces the single-alarm normal-mode counter under the watch top-level FSM, which now drives it through load strobes instead of digit-by-digit setting.

## Interface
Parameters:
- TICKS_PER_SEC, 1: clk cycles per second; must be ≥1; 1 means one second per cycle.
- NUM_ALARMS, 4: alarm table entries, 1..16.
- ALARM_SECS, 20: ring duration in seconds, 1..63.
- SNOOZE_MIN, 5: snooze delay in minutes, 1..59.

Ports. One clock; reset is asynchronous and active-high.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- time_load  in  1  load time_in_h/time_in_m; seconds and prescaler are cleared.
- time_in_h  in  6  BCD {tens[1:0],units[3:0]}.
- time_in_m  in  7  BCD {tens[2:0],units[3:0]}.
- alarm_wr  in  1  write one alarm entry.
- alarm_idx  in  IW  entry index; IW = max(1,$clog2(NUM_ALARMS)).
- alarm_in_h / alarm_in_m  in  6 / 7  BCD alarm time.
- alarm_in_en  in  1  entry enable.
- snooze  in  1  single-cycle request.
- dismiss  in  1  single-cycle request.
- fmt_12h  in  1  selects the 12-hour display view.
- hours_out  out  6  BCD display hours.
- minutes_out  out  7  BCD minutes.
- seconds_out  out  7  BCD seconds.
- pm  out  1  PM flag; 0 when fmt_12h=0.
- alarm_sound  out  1  high while in RING.
- ring_idx  out  IW  entry that caused the current or last ring.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- Time is held internally in 24-hour BCD. The prescaler counts 0..TICKS_PER_SEC-1; sec_tick is high on its last count.
- On sec_tick, seconds advance 59→00 with a minute carry, minutes advance 59→00 with an hour carry, and hours wrap 23→00. Unit digits wrap 9→0 with a carry into the tens digit.
- Load validation: tens and units digits must be in range, and hours must be ≤23. An invalid time_load or alarm_wr changes nothing and pulses load_err. alarm_wr with alarm_idx ≥ NUM_ALARMS is also rejected.
- time_load has priority over the sec_tick increment in the same cycle.
- new_sec is a register equal to sec_tick delayed by one cycle.
- A match exists when new_sec=1, seconds=00, and at least one enabled entry equals the current hours:minutes. The lowest matching index wins. A time_load never creates new_sec, so loading straight onto an alarm time does not ring.
- FSM:
  - IDLE: on a match, latch ring_idx, clear ring_cnt, go to RING.
  - RING: increment ring_cnt on each sec_tick. Go to IDLE when ring_cnt reaches ALARM_SECS, or on dismiss. On snooze, load snz_cnt = SNOOZE_MIN*60 and go to SNOOZE.
  - SNOOZE: decrement snz_cnt on each sec_tick. When it reaches 0, go to RING with ring_cnt cleared. dismiss goes to IDLE.
- Dismiss wins over a simultaneous snooze.
- Matches are ignored in RING and SNOOZE.
- time_load forces IDLE from any state.
- alarm_wr during RING or SNOOZE updates the table but does not cancel the active ring.
- 12-hour view (combinational from the registers, fmt_12h=1):
  - h=00 → 12, pm=0.
  - 01–11 → unchanged, pm=0.
  - 12 → 12, pm=1.
  - 13–23 → h−12, pm=1.
- Reset: time 00:00:00, prescaler 0, all entries disabled at 00:00, FSM IDLE, alarm_sound=0, ring_idx=0, load_err=0, pm=0.

## Timing
- All state is registered on the clk rising edge; rst acts immediately and asynchronously.
- A load is visible on the outputs one cycle after the time_load/alarm_wr cycle. load_err is high for exactly that one cycle.
- Alarm latency: edge E makes seconds 00; new_sec is high in the following cycle; alarm_sound rises at edge E+2.
- Ring length: RING lasts until the ALARM_SECS-th sec_tick after entry; alarm_sound falls on that edge.
- Dismiss and snooze act on the edge that samples them, so alarm_sound falls one cycle after dismiss or snooze is asserted.
- Prescaler and time keep running in every FSM state.

## Test plan
- Load 23:59, TICKS_PER_SEC=1, run 60 cycles → outputs 00:00:00; the hour, minute and second wraps are all checked.
- Write time_in_h=24, and separately time_in_m={6,0} → load_err pulses 1 cycle; time is unchanged.
- Entry 2 set to 07:30 enabled, load 07:29 → alarm_sound rises at edge E+2 after 07:30:00 and stays high 20 s; ring_idx=2.
- Entries 1 and 3 both set to 08:00 → ring_idx=1. During the ring, assert snooze and dismiss together → IDLE, no snooze.
- Ring, then snooze with SNOOZE_MIN=1 → alarm_sound is low for 60 s, then re-rings at 08:01:00+. Then assert rst mid-SNOOZE → all outputs return to reset values immediately.
- fmt_12h=1 at 00:15, 12:00 and 13:05 → displays 12:15 pm=0, 12:00 pm=1, 01:05 pm=1.
